// File: rtl/alu_fe_pkg.sv
// Shared types and constants for the ALU UART front end.
// The optional ALU_FE_CHECKSUM_EN macro adds a checksum transmit state.
package alu_fe_pkg;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;

    localparam int                    RX_BIT_W    = 3;
    localparam logic [RX_BIT_W-1:0]   RX_LAST_BIT = 3'd7;
    localparam int                    TX_BIT_W    = 4;
    localparam logic [TX_BIT_W-1:0]   TX_LAST_BIT = 4'd9;

    typedef enum logic [2:0] {
        ST_WAIT_OP,
        ST_WAIT_OPND,
        ST_ISSUE,
        ST_SETTLE,
`ifdef ALU_FE_CHECKSUM_EN
        ST_SEND,
        ST_SEND_CKS
`else
        ST_SEND
`endif
    } fe_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/alu_fe_uart_tx.sv
// 8N1 UART transmitter: start loads a 10-bit frame, done pulses in the last stop-bit cycle.
// A start arriving together with done chains the next byte with no idle gap.
module alu_fe_uart_tx
    import alu_fe_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       done_o
);
    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

    logic                busy_q;
    logic [TX_BIT_W-1:0] idx_q;
    logic [CW-1:0]       cnt_q;
    logic [9:0]          shift_q;

    assign done_o = busy_q && (idx_q == TX_LAST_BIT) && (cnt_q == BIT_END);
    assign tx_o   = busy_q ? shift_q[0] : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '1;
        end else if (start_i && (!busy_q || done_o)) begin
            busy_q  <= 1'b1;
            idx_q   <= '0;
            cnt_q   <= '0;
            shift_q <= {1'b1, data_i, 1'b0};
        end else if (busy_q) begin
            if (cnt_q == BIT_END) begin
                cnt_q   <= '0;
                shift_q <= {1'b1, shift_q[9:1]};
                if (idx_q == TX_LAST_BIT) busy_q <= 1'b0;
                else                      idx_q  <= idx_q + 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_uart_frontend.sv
// UART command front end for the 4-bit ALU: RX, frame FSM, ALU capture, result transmit.
// Define ALU_FE_CHECKSUM_EN to append a checksum byte (byte0 ^ byte1 ^ result).
module alu_uart_frontend
    import alu_fe_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       tx_o,
    output logic [3:0] alu_opcode_o,
    output logic [7:0] alu_operand_o,
    input  logic [7:0] alu_result_i,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       overrun_o
);
    localparam int            CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam int            SW         = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_CYCLES - 1);

    logic                rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e           rx_st_q;
    logic [CW-1:0]       rx_cnt_q;
    logic [RX_BIT_W-1:0] rx_bit_q;
    logic [7:0]          rx_sh_q;
    logic                rx_brk_q, rx_vld_q, rx_ferr_q;

    fe_state_e           state_q, state_d;
    logic [3:0]          op_pend_q, alu_opcode_q;
    logic [7:0]          opnd_pend_q, alu_operand_q;
    logic [SW-1:0]       settle_q;
    logic                ovr_q;
    logic                tx_start, tx_done;
    logic [7:0]          tx_data;

    // After a bad stop bit the start re-check waits a full bit, so a held-low
    // line keeps a strict 10-bit cadence and a released line returns to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= RX_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_brk_q  <= 1'b0;
            rx_vld_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_vld_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
            case (rx_st_q)
                RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
                    rx_st_q  <= RX_START;
                    rx_cnt_q <= '0;
                    rx_brk_q <= 1'b0;
                end
                RX_START: if (rx_cnt_q == (rx_brk_q ? BIT_END : HALF_END)) begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
                end else rx_cnt_q <= rx_cnt_q + 1'b1;
                RX_DATA: if (rx_cnt_q == BIT_END) begin
                    rx_cnt_q <= '0;
                    rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_q <= rx_bit_q + 1'b1;
                    if (rx_bit_q == RX_LAST_BIT) rx_st_q <= RX_STOP;
                end else rx_cnt_q <= rx_cnt_q + 1'b1;
                RX_STOP: if (rx_cnt_q == BIT_END) begin
                    rx_cnt_q <= '0;
                    if (rx_s2_q) begin
                        rx_vld_q <= 1'b1;
                        rx_st_q  <= RX_IDLE;
                    end else begin
                        rx_ferr_q <= 1'b1;
                        rx_brk_q  <= 1'b1;
                        rx_st_q   <= RX_START;
                    end
                end else rx_cnt_q <= rx_cnt_q + 1'b1;
                default: rx_st_q <= RX_IDLE;
            endcase
        end
    end

`ifdef ALU_FE_CHECKSUM_EN
    logic [7:0] res_q;
    logic [7:0] cks;
    assign cks = {SYNC_NIBBLE, alu_opcode_q} ^ alu_operand_q ^ res_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_WAIT_OP;
        else     state_q <= state_d;
    end

    // The result is handed to the TX shift register in the same cycle it is sampled.
    always_comb begin
        state_d  = state_q;
        tx_start = 1'b0;
        tx_data  = alu_result_i;
        case (state_q)
            ST_WAIT_OP:   if (rx_vld_q && rx_sh_q[7:4] == SYNC_NIBBLE) state_d = ST_WAIT_OPND;
            ST_WAIT_OPND: if (rx_vld_q)       state_d = ST_ISSUE;
                          else if (rx_ferr_q) state_d = ST_WAIT_OP;
            ST_ISSUE:     state_d = ST_SETTLE;
            ST_SETTLE:    if (settle_q == SETTLE_END) begin
                state_d  = ST_SEND;
                tx_start = 1'b1;
            end
`ifdef ALU_FE_CHECKSUM_EN
            ST_SEND:      if (tx_done) begin
                state_d  = ST_SEND_CKS;
                tx_start = 1'b1;
                tx_data  = cks;
            end
            ST_SEND_CKS:  if (tx_done) state_d = ST_WAIT_OP;
`else
            ST_SEND:      if (tx_done) state_d = ST_WAIT_OP;
`endif
            default:      state_d = ST_WAIT_OP;
        endcase
    end

    assign busy_o = (state_q != ST_WAIT_OP) && (state_q != ST_WAIT_OPND);

    always_ff @(posedge clk) begin
        if (rst) begin
            op_pend_q     <= '0;
            opnd_pend_q   <= '0;
            alu_opcode_q  <= '0;
            alu_operand_q <= '0;
            settle_q      <= '0;
            ovr_q         <= 1'b0;
`ifdef ALU_FE_CHECKSUM_EN
            res_q         <= '0;
`endif
        end else begin
            ovr_q <= rx_vld_q && busy_o;
            if (state_q == ST_WAIT_OP && rx_vld_q)   op_pend_q   <= rx_sh_q[3:0];
            if (state_q == ST_WAIT_OPND && rx_vld_q) opnd_pend_q <= rx_sh_q;
            if (state_q == ST_ISSUE) begin
                alu_opcode_q  <= op_pend_q;
                alu_operand_q <= opnd_pend_q;
                settle_q      <= '0;
            end
            if (state_q == ST_SETTLE) begin
                settle_q <= settle_q + 1'b1;
`ifdef ALU_FE_CHECKSUM_EN
                if (settle_q == SETTLE_END) res_q <= alu_result_i;
`endif
            end
        end
    end

    assign alu_opcode_o  = alu_opcode_q;
    assign alu_operand_o = alu_operand_q;
    assign frame_err_o   = rx_ferr_q;
    assign overrun_o     = ovr_q;

    alu_fe_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .start_i(tx_start),
        .data_i (tx_data),
        .tx_o   (tx_o),
        .done_o (tx_done)
    );

endmodule

// File: tb/tb_alu_uart_frontend.sv
// Self-checking bench for alu_uart_frontend: serial frames in, decoded result bytes out,
// compared against an arithmetic ALU/checksum model; honours ALU_FE_CHECKSUM_EN.
module tb_alu_uart_frontend;
    localparam int CPB = 4;
`ifdef ALU_FE_CHECKSUM_EN
    localparam int NRESP = 2;
`else
    localparam int NRESP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic       tx_o;
    logic [3:0] alu_opcode_o;
    logic [7:0] alu_operand_o;
    logic [7:0] alu_result_i;
    logic       busy_o, frame_err_o, overrun_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_uart_frontend #(.CLKS_PER_BIT(CPB), .SETTLE_CYCLES(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .tx_o         (tx_o),
        .alu_opcode_o (alu_opcode_o),
        .alu_operand_o(alu_operand_o),
        .alu_result_i (alu_result_i),
        .busy_o       (busy_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o)
    );

    // Behavioural ALU: {Zero,Carry,Sign,Error,Result}
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] w;
        logic [7:0] p;
        logic       e;
        w = 5'd0; p = 8'd0; e = 1'b0;
        case (op)
            4'h0: w = {1'b0, a} + {1'b0, b};
            4'h1: w = {1'b0, a} - {1'b0, b};
            4'h2: begin p = a * b; w = {|p[7:4], p[3:0]}; end
            4'h3: if (b == 4'd0) e = 1'b1; else w = {1'b0, a / b};
            4'h4: w = {1'b0, a & b};
            4'h5: w = {1'b0, a | b};
            4'h6: w = {1'b0, a ^ b};
            default: e = 1'b1;
        endcase
        return {(w[3:0] == 4'd0), w[4], w[3], e, w[3:0]};
    endfunction

    assign alu_result_i = alu_fn(alu_opcode_o, alu_operand_o[3:0], alu_operand_o[7:4]);

    // Serial monitor on tx_o: samples each bit in its middle, drops frames cut by reset
    logic [7:0] got_q[$];
    logic [7:0] mon_b;
    logic       mon_bad;
    initial begin
        forever begin
            @(negedge clk);
            if (!tx_o && !rst) begin
                mon_bad = 1'b0;
                mon_b   = 8'd0;
                repeat (CPB / 2) begin @(negedge clk); if (rst) mon_bad = 1'b1; end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(negedge clk); if (rst) mon_bad = 1'b1; end
                    mon_b[i] = tx_o;
                end
                repeat (CPB) begin @(negedge clk); if (rst) mon_bad = 1'b1; end
                if (tx_o !== 1'b1) mon_bad = 1'b1;
                if (!mon_bad) got_q.push_back(mon_b);
            end
        end
    end

    logic tx_prev = 1'b1;
    int   tx_fall = 0;
    int   ferr_cnt = 0;
    int   ovr_cnt = 0;
    always @(negedge clk) begin
        tx_prev <= tx_o;
        if (tx_prev && !tx_o) tx_fall <= tx_fall + 1;
        if (frame_err_o)      ferr_cnt <= ferr_cnt + 1;
        if (overrun_o)        ovr_cnt <= ovr_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] got(input int i);
        return (got_q.size() > i) ? got_q[i] : 8'hxx;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = f[i];
            tick(CPB);
        end
        rx_i = 1'b1;
        if (gap > 0) tick(gap * CPB);
    endtask

    task automatic wait_resp(input int n, input string name);
        int t;
        t = 0;
        while ((got_q.size() < n || busy_o) && t < 1000) begin
            tick(1);
            t++;
        end
        chk(name, got_q.size(), n);
    endtask

    task automatic check_frame(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] er, input logic [7:0] ec, input string name);
        got_q.delete();
        send_byte(b0, 1'b1, 1);
        send_byte(b1, 1'b1, 1);
        wait_resp(NRESP, {name, " count"});
        chk({name, " result"}, got(0), er);
`ifdef ALU_FE_CHECKSUM_EN
        chk({name, " cks"}, got(1), ec);
`endif
        chk({name, " opcode"}, alu_opcode_o, b0[3:0]);
        chk({name, " operand"}, alu_operand_o, b1);
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] res;
        logic [7:0] cks;
    } vec_t;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   f0, e0, o0, t;
        logic [3:0] op;
        logic [7:0] opnd, j, er, ec;

        vecs[0] = '{8'hA0, 8'h53, 8'h28, 8'hDB};
        vecs[1] = '{8'hA3, 8'h03, 8'h90, 8'h30};
        vecs[2] = '{8'hA1, 8'h35, 8'h02, 8'h96};
        vecs[3] = '{8'hA2, 8'h44, 8'hC0, 8'h26};
        vecs[4] = '{8'hA4, 8'hF9, 8'h29, 8'h74};
        vecs[5] = '{8'hAF, 8'h12, 8'h90, 8'h2D};

        rst = 1'b1; rx_i = 1'b1;
        tick(3);
        chk("reset tx_o", tx_o, 1);
        chk("reset opcode", alu_opcode_o, 0);
        chk("reset operand", alu_operand_o, 0);
        chk("reset busy", busy_o, 0);
        chk("reset frame_err", frame_err_o, 0);
        chk("reset overrun", overrun_o, 0);
        rst = 1'b0;
        tick(5);

        for (int i = 0; i < 6; i++) check_frame(vecs[i].b0, vecs[i].b1, vecs[i].res, vecs[i].cks, $sformatf("vec%0d", i));

        // Non-sync first byte is ignored
        got_q.delete();
        f0 = tx_fall;
        send_byte(8'h50, 1'b1, 2);
        tick(20);
        chk("junk no tx", tx_fall - f0, 0);
        check_frame(8'hA0, 8'h53, 8'h28, 8'hDB, "after junk");

        // Frame error on byte0
        e0 = ferr_cnt; f0 = tx_fall;
        send_byte(8'hA0, 1'b0, 2);
        tick(10);
        chk("ferr b0 pulses", ferr_cnt - e0, 1);
        chk("ferr b0 no tx", tx_fall - f0, 0);
        check_frame(8'hA0, 8'h53, 8'h28, 8'hDB, "after ferr b0");

        // Frame error on byte1 discards the partial frame
        e0 = ferr_cnt; f0 = tx_fall;
        send_byte(8'hA0, 1'b1, 1);
        send_byte(8'h53, 1'b0, 2);
        send_byte(8'h53, 1'b1, 2);
        tick(60);
        chk("ferr b1 pulses", ferr_cnt - e0, 1);
        chk("ferr b1 no tx", tx_fall - f0, 0);
        check_frame(8'hA3, 8'h03, 8'h90, 8'h30, "after ferr b1");

        // Third byte arriving while the result is being sent
        got_q.delete();
        o0 = ovr_cnt;
        send_byte(8'hA0, 1'b1, 0);
        send_byte(8'h53, 1'b1, 0);
        send_byte(8'hA1, 1'b1, 2);
        wait_resp(NRESP, "overrun count");
        chk("overrun result", got(0), 8'h28);
`ifdef ALU_FE_CHECKSUM_EN
        chk("overrun cks", got(1), 8'hDB);
`endif
        chk("overrun pulses", ovr_cnt - o0, 1);
        f0 = tx_fall;
        send_byte(8'h53, 1'b1, 2);
        tick(60);
        chk("overrun byte dropped", tx_fall - f0, 0);

        // Reset during TX data bit 3
        got_q.delete();
        send_byte(8'hA0, 1'b1, 0);
        send_byte(8'h53, 1'b1, 0);
        t = 0;
        while (tx_o && t < 200) begin tick(1); t++; end
        chk("tx start seen", tx_o, 0);
        tick(4 * CPB + 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst mid-tx tx_o", tx_o, 1);
        chk("rst mid-tx busy", busy_o, 0);
        chk("rst mid-tx opcode", alu_opcode_o, 0);
        chk("rst mid-tx operand", alu_operand_o, 0);
        f0 = tx_fall;
        tick(100);
        chk("rst mid-tx no edges", tx_fall - f0, 0);
        chk("rst mid-tx no byte", got_q.size(), 0);

        // RX line held low for three 10-bit periods
        e0 = ferr_cnt; f0 = tx_fall;
        rx_i = 1'b0;
        tick(30 * CPB);
        rx_i = 1'b1;
        tick(60);
        chk("stuck low ferr", ferr_cnt - e0, 3);
        chk("stuck low no tx", tx_fall - f0, 0);
        chk("stuck low busy", busy_o, 0);
        check_frame(8'hA0, 8'h53, 8'h28, 8'hDB, "after stuck low");

        // Randomised frames against the arithmetic model
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                j = 8'($urandom);
                if (j[7:4] == 4'hA) j[7:4] = 4'h5;
                send_byte(j, 1'b1, 1);
            end
            op   = 4'($urandom_range(0, 15));
            opnd = 8'($urandom);
            er   = alu_fn(op, opnd[3:0], opnd[7:4]);
            ec   = {4'hA, op} ^ opnd ^ er;
            check_frame({4'hA, op}, opnd, er, ec, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
